// File: rtl/adder_share_arb_if.sv
// Bundle between the adder arbiter and its clients: two requesters,
// the shared pipelined adder, and the response/status lines.
//   slave  : arbiter side (requests, adder sum in; grants, operands, responses out)
//   master : environment side (requesters plus adder)
interface adder_share_arb_if #(
    parameter int unsigned WIDTH = 32
);
    logic             add_hold;

    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic             req0_sub;
    logic             req0_cin;

    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic             req1_sub;
    logic             req1_cin;

    logic             add_valid;
    logic [WIDTH-1:0] add_a;
    logic [WIDTH-1:0] add_b;
    logic             add_cin;
    logic [WIDTH-1:0] add_sum;
    logic             add_cout;

    logic             rsp0_valid;
    logic             rsp1_valid;
    logic [WIDTH-1:0] rsp_sum;
    logic             rsp_cout;
    logic             busy;

    modport slave (
        input  add_hold,
        input  req0_valid, req0_a, req0_b, req0_sub, req0_cin,
        input  req1_valid, req1_a, req1_b, req1_sub, req1_cin,
        input  add_sum, add_cout,
        output req0_ready, req1_ready,
        output add_valid, add_a, add_b, add_cin,
        output rsp0_valid, rsp1_valid, rsp_sum, rsp_cout, busy
    );

    modport master (
        output add_hold,
        output req0_valid, req0_a, req0_b, req0_sub, req0_cin,
        output req1_valid, req1_a, req1_b, req1_sub, req1_cin,
        output add_sum, add_cout,
        input  req0_ready, req1_ready,
        input  add_valid, add_a, add_b, add_cin,
        input  rsp0_valid, rsp1_valid, rsp_sum, rsp_cout, busy
    );
endinterface

// File: rtl/adder_share_arb.sv
// Round-robin arbiter sharing one pipelined adder between the integer ALU
// (requester 0) and the address generator (requester 1). Operands are muxed
// combinationally onto the adder; a tag pipe of ADD_LAT stages remembers who
// issued each operation so the result can be steered back.
// Ports:
//   clk  - clock
//   rst  - asynchronous active-high reset
//   bus  - adder_share_arb_if.slave: requests, adder operands/sum, responses, busy
module adder_share_arb #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned ADD_LAT = 2,
    parameter int unsigned MAX_OUT = 2
) (
    input  logic               clk,
    input  logic               rst,
    adder_share_arb_if.slave   bus
);

    localparam int unsigned CNT_W = $clog2(MAX_OUT + 1);

    logic [ADD_LAT-1:0] r_tag_vld;
    logic [ADD_LAT-1:0] r_tag_id;
    logic [CNT_W-1:0]   r_cnt0;
    logic [CNT_W-1:0]   r_cnt1;
    logic               r_ptr;

    logic               w_elig0;
    logic               w_elig1;
    logic               w_gnt0;
    logic               w_gnt1;
    logic               w_issue;
    logic               w_rsp0;
    logic               w_rsp1;
    logic [WIDTH-1:0]   w_op_a;
    logic [WIDTH-1:0]   w_op_b;
    logic               w_op_sub;
    logic               w_op_cin;

    // Eligibility and grant; ready depends on valid in the same cycle.
    always_comb begin
        w_elig0 = ~rst & bus.req0_valid & (r_cnt0 < CNT_W'(MAX_OUT)) & ~bus.add_hold;
        w_elig1 = ~rst & bus.req1_valid & (r_cnt1 < CNT_W'(MAX_OUT)) & ~bus.add_hold;
        w_gnt0  = w_elig0 & (~w_elig1 | ~r_ptr);
        w_gnt1  = w_elig1 & (~w_elig0 |  r_ptr);
        w_issue = w_gnt0 | w_gnt1;
    end

    // Operand select; everything stays zero on a no-issue cycle.
    always_comb begin
        w_op_a   = '0;
        w_op_b   = '0;
        w_op_sub = 1'b0;
        w_op_cin = 1'b0;
        if (w_gnt0) begin
            w_op_a   = bus.req0_a;
            w_op_b   = bus.req0_b;
            w_op_sub = bus.req0_sub;
            w_op_cin = bus.req0_cin;
        end else if (w_gnt1) begin
            w_op_a   = bus.req1_a;
            w_op_b   = bus.req1_b;
            w_op_sub = bus.req1_sub;
            w_op_cin = bus.req1_cin;
        end
    end

    // Subtract is a + ~b + 1.
    assign bus.add_valid  = w_issue;
    assign bus.add_a      = w_op_a;
    assign bus.add_b      = w_op_sub ? ~w_op_b : w_op_b;
    assign bus.add_cin    = w_op_sub | w_op_cin;
    assign bus.req0_ready = w_gnt0;
    assign bus.req1_ready = w_gnt1;

    // Response steering from the last tag stage; suppressed while frozen.
    always_comb begin
        w_rsp0 = ~rst & ~bus.add_hold & r_tag_vld[ADD_LAT-1] & ~r_tag_id[ADD_LAT-1];
        w_rsp1 = ~rst & ~bus.add_hold & r_tag_vld[ADD_LAT-1] &  r_tag_id[ADD_LAT-1];
    end

    assign bus.rsp0_valid = w_rsp0;
    assign bus.rsp1_valid = w_rsp1;
    assign bus.rsp_sum    = rst ? '0 : bus.add_sum;
    assign bus.rsp_cout   = ~rst & bus.add_cout;
    assign bus.busy       = |r_tag_vld;

    // Tag pipe, outstanding counters and round-robin pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tag_vld <= '0;
            r_tag_id  <= '0;
            r_cnt0    <= '0;
            r_cnt1    <= '0;
            r_ptr     <= 1'b0;
        end else if (!bus.add_hold) begin
            r_tag_vld[0] <= w_issue;
            r_tag_id[0]  <= w_gnt1;
            for (int i = 1; i < int'(ADD_LAT); i++) begin
                r_tag_vld[i] <= r_tag_vld[i-1];
                r_tag_id[i]  <= r_tag_id[i-1];
            end
            r_cnt0 <= r_cnt0 + CNT_W'(w_gnt0) - CNT_W'(w_rsp0);
            r_cnt1 <= r_cnt1 + CNT_W'(w_gnt1) - CNT_W'(w_rsp1);
            // Pointer moves to the loser of this issue.
            if (w_issue) begin
                r_ptr <= w_gnt0;
            end
        end
    end

    // Counters must stay within 0..MAX_OUT.
    a_cnt0_ovf: assert property (@(posedge clk) disable iff (rst)
        !(w_gnt0 && !w_rsp0 && (r_cnt0 == CNT_W'(MAX_OUT))));
    a_cnt1_ovf: assert property (@(posedge clk) disable iff (rst)
        !(w_gnt1 && !w_rsp1 && (r_cnt1 == CNT_W'(MAX_OUT))));
    a_cnt0_udf: assert property (@(posedge clk) disable iff (rst)
        !(w_rsp0 && !w_gnt0 && (r_cnt0 == '0)));
    a_cnt1_udf: assert property (@(posedge clk) disable iff (rst)
        !(w_rsp1 && !w_gnt1 && (r_cnt1 == '0)));

endmodule
